// File: rtl/q_change_monitor_pkg.sv
// Shared types and default sizes for the Q-bus change monitor.
package q_mon_pkg;

    localparam int Q_W_DEF   = 3;
    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [Q_W_DEF-1:0]  q;
        logic [TS_W_DEF-1:0] ts;
    } q_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BASE = 2'd1,
        RUN  = 2'd2
    } q_mon_state_t;

endpackage

// File: rtl/q_change_monitor_sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible whenever valid=1.
// Output data reads as zero while empty so nothing uninitialised leaks out.
module sync_fifo_fwft #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = q_mon_pkg::q_entry_t
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && valid;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/q_change_monitor.sv
// Watches the Q bus, logs a baseline plus every value change with a cycle
// timestamp, and buffers the log in a FWFT FIFO read over valid/ready.
module q_change_monitor
    import q_mon_pkg::*;
#(
    parameter int Q_W   = Q_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   arm,
    input  logic                   clr,
    input  logic [Q_W-1:0]         q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_W-1:0]         out_q,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            changes,
    output q_mon_state_t           state
);

    // Handshake: an entry moves on an edge where out_valid && out_ready; the
    // head holds steady while out_valid=1 and out_ready=0.

    typedef struct packed {
        logic [Q_W-1:0]  q;
        logic [TS_W-1:0] ts;
    } entry_t;

    localparam logic [TS_W-1:0] TS_MAX = '1;

    q_mon_state_t    next_state;
    logic [Q_W-1:0]  q_r;
    logic [Q_W-1:0]  last_q;
    logic [TS_W-1:0] ts;
    logic            push;
    logic            pop;
    logic            changed;
    logic            fifo_full;
    entry_t          push_entry;
    entry_t          head;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!arm) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = BASE;
                BASE:    next_state = RUN;
                RUN:     next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        push          = 1'b0;
        changed       = 1'b0;
        push_entry    = '0;
        if (arm) begin
            case (state)
                BASE: begin
                    push          = 1'b1;
                    push_entry.q  = q_r;
                    push_entry.ts = '0;
                end
                RUN: begin
                    if (q_r != last_q) begin
                        push          = 1'b1;
                        changed       = 1'b1;
                        push_entry.q  = q_r;
                        push_entry.ts = ts;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop = out_valid && out_ready;

    // last_q follows every logged value even when the entry is dropped or flushed.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_r      <= '0;
            last_q   <= '0;
            ts       <= '0;
            overflow <= 1'b0;
            changes  <= '0;
        end else begin
            q_r <= q;
            if (push) last_q <= q_r;
            if (clr) begin
                ts       <= '0;
                overflow <= 1'b0;
                changes  <= '0;
            end else begin
                if (arm && state == BASE)
                    ts <= TS_W'(1);
                else if (arm && state == RUN && ts != TS_MAX)
                    ts <= ts + TS_W'(1);
                if (push && fifo_full && !pop) overflow <= 1'b1;
                if (changed && changes != 16'hFFFF) changes <= changes + 16'd1;
            end
        end
    end

    sync_fifo_fwft #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .clr   (clr),
        .push  (push && !clr),
        .pop   (pop && !clr),
        .din   (push_entry),
        .dout  (head),
        .valid (out_valid),
        .full  (fifo_full),
        .count (count)
    );

    assign out_q  = head.q;
    assign out_ts = head.ts;

endmodule

// File: tb/tb_q_change_monitor.sv
// Bench for q_change_monitor: two instances (TS_W=8 and TS_W=4) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_q_change_monitor;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic arm = 1'b0;
    logic clr = 1'b0;
    logic out_ready = 1'b0;
    logic [2:0] q = 3'd0;

    logic        v8, v4;
    logic [2:0]  q8, q4;
    logic [7:0]  ts8;
    logic [3:0]  ts4;
    logic [3:0]  cnt8, cnt4;
    logic        ov8, ov4;
    logic [15:0] ch8, ch4;
    q_mon_pkg::q_mon_state_t st8, st4;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    q_change_monitor #(.Q_W(3), .TS_W(8), .DEPTH(DEPTH)) dut8 (
        .clk(clk), .rstN(rstN), .arm(arm), .clr(clr), .q(q),
        .out_valid(v8), .out_ready(out_ready), .out_q(q8), .out_ts(ts8),
        .count(cnt8), .overflow(ov8), .changes(ch8), .state(st8)
    );

    q_change_monitor #(.Q_W(3), .TS_W(4), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .rstN(rstN), .arm(arm), .clr(clr), .q(q),
        .out_valid(v4), .out_ready(out_ready), .out_q(q4), .out_ts(ts4),
        .count(cnt4), .overflow(ov4), .changes(ch4), .state(st4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Entries are kept as q*256+ts; phase 0/1/2 = idle / baseline / running.
    int mq[2][$];
    int m_phase[2];
    int m_last[2];
    int m_ts[2];
    int m_chg[2];
    int m_over[2];
    int ts_max[2] = '{255, 15};
    int m_qr;
    int m_ent;
    bit m_pop;
    bit m_push;

    initial begin
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                m_qr = 0;
                for (int i = 0; i < 2; i++) begin
                    mq[i].delete();
                    m_phase[i] = 0; m_last[i] = 0; m_ts[i] = 0;
                    m_chg[i] = 0; m_over[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    m_pop  = (mq[i].size() > 0) && out_ready;
                    m_push = 1'b0;
                    m_ent  = 0;
                    if (!arm) begin
                        m_phase[i] = 0;
                    end else if (m_phase[i] == 0) begin
                        m_phase[i] = 1;
                    end else if (m_phase[i] == 1) begin
                        m_push = 1'b1;
                        m_ent = m_qr * 256;
                        m_last[i] = m_qr;
                        m_ts[i] = 1;
                        m_phase[i] = 2;
                    end else begin
                        if (m_qr != m_last[i]) begin
                            m_push = 1'b1;
                            m_ent = m_qr * 256 + m_ts[i];
                            m_last[i] = m_qr;
                            if (m_chg[i] < 65535) m_chg[i]++;
                        end
                        if (m_ts[i] < ts_max[i]) m_ts[i]++;
                    end
                    if (clr) begin
                        mq[i].delete();
                        m_over[i] = 0; m_chg[i] = 0; m_ts[i] = 0;
                    end else begin
                        if (m_pop) void'(mq[i].pop_front());
                        if (m_push) begin
                            if (mq[i].size() < DEPTH) mq[i].push_back(m_ent);
                            else m_over[i] = 1;
                        end
                    end
                end
                m_qr = int'(q);
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic cmp_inst(input int i, input int v, input int oq, input int ots,
                            input int cnt, input int ov, input int ch, input int st);
        int head;
        head = (mq[i].size() > 0) ? mq[i][0] : 0;
        chk($sformatf("valid%0d", i), v, int'(mq[i].size() > 0));
        chk($sformatf("out_q%0d", i), oq, head / 256);
        chk($sformatf("out_ts%0d", i), ots, head % 256);
        chk($sformatf("count%0d", i), cnt, mq[i].size());
        chk($sformatf("overflow%0d", i), ov, m_over[i]);
        chk($sformatf("changes%0d", i), ch, m_chg[i]);
        chk($sformatf("state%0d", i), st, m_phase[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, int'(v8), int'(q8), int'(ts8), int'(cnt8), int'(ov8), int'(ch8), int'(st8));
            cmp_inst(1, int'(v4), int'(q4), int'(ts4), int'(cnt4), int'(ov4), int'(ch4), int'(st4));
        end
    end

    // ---------------- driver ----------------
    // Inputs change 2 time units after a rising edge; checks right after tick()
    // see the state produced by that edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        tick(3);
        rstN = 1'b1;
        tick(1);
        chk("rst_valid", int'(v8), 0);
        chk("rst_count", int'(cnt8), 0);
        chk("rst_changes", int'(ch8), 0);

        // baseline: first entry appears two edges after arm
        q = 3'd2; arm = 1'b1;
        tick(1);
        chk("base_early_valid", int'(v8), 0);
        tick(1);
        chk("base_valid", int'(v8), 1);
        chk("base_q", int'(q8), 2);
        chk("base_ts", int'(ts8), 0);

        // changes: 2 -> 5 held 4 cycles -> 7
        q = 3'd5;
        tick(4);
        q = 3'd7;
        tick(3);
        chk("chg_count", int'(cnt8), 3);
        chk("chg_changes", int'(ch8), 2);
        tick(3);
        chk("hold_count", int'(cnt8), 3);
        out_ready = 1'b1;
        tick(1);
        chk("chg1_q", int'(q8), 5);
        chk("chg1_ts", int'(ts8), 2);
        tick(1);
        chk("chg2_q", int'(q8), 7);
        chk("chg2_ts", int'(ts8), 6);
        chk("chg2_ts4", int'(ts4), 6);
        tick(1);
        chk("drain_valid", int'(v8), 0);
        out_ready = 1'b0;

        // reset with three entries queued
        q = 3'd1; tick(2);
        q = 3'd4; tick(2);
        q = 3'd6; tick(3);
        chk("prerst_count", int'(cnt8), 3);
        rstN = 1'b0;
        #1;
        chk("midrst_valid", int'(v8), 0);
        chk("midrst_count", int'(cnt8), 0);
        chk("midrst_q", int'(q8), 0);
        chk("midrst_changes", int'(ch8), 0);
        arm = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(1);
        chk("postrst_valid", int'(v8), 0);

        // overflow: baseline + 10 changes into 8 entries
        q = 3'd3; arm = 1'b1;
        tick(2);
        for (int k = 0; k < 10; k++) begin
            q = (k % 2 == 1) ? 3'd6 : 3'd1;
            tick(1);
        end
        tick(3);
        chk("ovf_count", int'(cnt8), 8);
        chk("ovf_flag", int'(ov8), 1);
        chk("ovf_changes", int'(ch8), 10);
        chk("ovf_head_q", int'(q8), 3);
        chk("ovf_head_ts", int'(ts8), 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_count", int'(cnt8), 0);
        chk("clr_overflow", int'(ov8), 0);
        chk("clr_changes", int'(ch8), 0);

        // full with simultaneous pop
        for (int k = 0; k < 8; k++) begin
            q = (k % 2 == 1) ? 3'd6 : 3'd1;
            tick(1);
        end
        tick(2);
        chk("fill_count", int'(cnt8), 8);
        chk("fill_overflow", int'(ov8), 0);
        q = 3'd1;
        tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("fullpop_count", int'(cnt8), 8);
        chk("fullpop_overflow", int'(ov8), 0);

        // timestamp saturation, then disarm and drain
        arm = 1'b0;
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        q = 3'd4; arm = 1'b1;
        tick(2);
        tick(18);
        q = 3'd5;
        tick(2);
        arm = 1'b0;
        q = 3'd2;
        tick(3);
        chk("sat_count8", int'(cnt8), 2);
        chk("sat_count4", int'(cnt4), 2);
        chk("sat_head_q", int'(q8), 4);
        out_ready = 1'b1;
        tick(1);
        chk("sat_q", int'(q8), 5);
        chk("sat_ts8", int'(ts8), 20);
        chk("sat_ts4", int'(ts4), 15);
        tick(1);
        chk("sat_drain8", int'(v8), 0);
        chk("sat_drain4", int'(v4), 0);
        out_ready = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) q = 3'($urandom_range(0, 7));
            if ((c / 500) % 2 == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                    out_ready = ($urandom_range(0, 3) == 0);
            arm  = ($urandom_range(0, 19) != 0);
            clr  = ($urandom_range(0, 49) == 0);
            rstN = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rstN = 1'b1; clr = 1'b0; arm = 1'b0; out_ready = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
